// File: rtl/mips_lsu_pkg.sv
// Shared types for the MIPS load/store unit: request op encoding, FSM states,
// response error codes and access-size constants.
package mips_lsu_pkg;

    typedef struct packed {
        logic       is_store;
        logic       is_unsigned;
        logic [1:0] size;
    } lsu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } lsu_err_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

endpackage

// File: rtl/mips_lsu_lane_align.sv
// Byte-lane steering between a big-endian cache word (byte 0 = MSB) and the
// core: load extract with sign/zero extension, and sub-word store merge.
module mips_lsu_lane_align #(
    parameter int XLEN = 32
) (
    input  logic [1:0]                size,
    input  logic                      is_unsigned,
    input  logic [$clog2(XLEN/8)-1:0] lane,
    input  logic [XLEN-1:0]           rd_word,
    input  logic [XLEN-1:0]           wdata,
    output logic [XLEN-1:0]           load_data,
    output logic [XLEN-1:0]           merged_word
);

    localparam int NBYTES = XLEN / 8;

    logic sign;
    int   nb;

    // Value byte j (LSB = 0) pairs with cache byte lane+nb-1-j, so the lowest
    // cache index lands in the most significant value byte.
    always_comb begin
        nb   = 1 << size;
        sign = 1'b0;
        for (int k = 0; k < NBYTES; k++)
            if (k == int'(lane))
                sign = rd_word[8*(NBYTES-k)-1] & ~is_unsigned;
        load_data   = {XLEN{sign}};
        merged_word = rd_word;
        for (int j = 0; j < NBYTES; j++)
            for (int k = 0; k < NBYTES; k++)
                if (j < nb && k == int'(lane) + nb - 1 - j) begin
                    load_data[8*j +: 8]               = rd_word[8*(NBYTES-1-k) +: 8];
                    merged_word[8*(NBYTES-1-k) +: 8]  = wdata[8*j +: 8];
                end
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit between the MIPS datapath and the data cache: one request at
// a time, alignment checks, read-modify-write for sub-word stores, miss timeout.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NBYTES   = XLEN / 8,
    parameter int MAX_WAIT = 64
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                req_valid,
    output logic                req_ready,
    input  lsu_op_t             req_op,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [4:0]          req_rd,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [4:0]          resp_rd,
    output logic [1:0]          resp_err,
    output logic                cache_en,
    output logic [XLEN-1:0]     cache_addr,
    output logic                cache_write_en,
    output logic [8*NBYTES-1:0] cache_data_in,
    input  logic [8*NBYTES-1:0] cache_data_out,
    input  logic                hit
);

    localparam int LW = $clog2(NBYTES);
    localparam int CW = $clog2(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    lsu_state_t      state, next_state;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [XLEN-1:0] addr_q, wr_word_q, load_data, merged_word, next_rdata, size_mask;
    logic [4:0]      rd_q;
    logic [CW-1:0]   wait_q;
    logic            resp_load, rmw_load, timed_out, req_illegal, req_misalign;
    lsu_err_t        next_err;

    assign req_ready     = (state == IDLE);
    assign size_mask     = (XLEN'(1) << req_op.size) - XLEN'(1);
    assign req_illegal   = (int'(req_op.size) > LW);
    assign req_misalign  = |(req_addr & size_mask);
    assign timed_out     = (wait_q == WAIT_LAST) && !hit;
    assign cache_addr    = {addr_q[XLEN-1:LW], {LW{1'b0}}};
    assign cache_data_in = wr_word_q;

    mips_lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .lane        (addr_q[LW-1:0]),
        .rd_word     (cache_data_out),
        .wdata       (wr_word_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state     = state;
        resp_load      = 1'b0;
        rmw_load       = 1'b0;
        next_err       = ERR_OK;
        next_rdata     = '0;
        cache_en       = 1'b0;
        cache_write_en = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal) begin
                        next_state = RESP;
                        resp_load  = 1'b1;
                        next_err   = ERR_ILLEGAL;
                    end else if (req_misalign) begin
                        next_state = RESP;
                        resp_load  = 1'b1;
                        next_err   = ERR_MISALIGN;
                    end else if (!req_op.is_store) begin
                        next_state = READ;
                    end else if (int'(req_op.size) == LW) begin
                        next_state = WRITE;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            READ, RMW_RD: begin
                cache_en = 1'b1;
                if (hit) begin
                    if (state == READ) begin
                        next_state = RESP;
                        resp_load  = 1'b1;
                        next_rdata = load_data;
                    end else begin
                        next_state = RMW_WR;
                        rmw_load   = 1'b1;
                    end
                end else if (timed_out) begin
                    next_state = RESP;
                    resp_load  = 1'b1;
                    next_err   = ERR_TIMEOUT;
                end
            end
            WRITE, RMW_WR: begin
                cache_en       = 1'b1;
                cache_write_en = 1'b1;
                if (hit) begin
                    next_state = RESP;
                    resp_load  = 1'b1;
                end else if (timed_out) begin
                    next_state = RESP;
                    resp_load  = 1'b1;
                    next_err   = ERR_TIMEOUT;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The write word starts as the raw store data and becomes the merged word once the RMW read returns.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            size_q     <= '0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wr_word_q  <= '0;
            rd_q       <= '0;
        end else if (req_valid && req_ready) begin
            size_q     <= req_op.size;
            unsigned_q <= req_op.is_unsigned;
            addr_q     <= req_addr;
            wr_word_q  <= req_wdata;
            rd_q       <= req_rd;
        end else if (rmw_load) begin
            wr_word_q  <= merged_word;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                   wait_q <= '0;
        else if (next_state != state) wait_q <= '0;
        else if (cache_en)            wait_q <= wait_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_err   <= '0;
        end else begin
            resp_valid <= resp_load;
            if (resp_load) begin
                resp_rdata <= next_rdata;
                resp_err   <= next_err;
                resp_rd    <= req_ready ? req_rd : rd_q;
            end
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Randomised self-checking bench for mips_lsu against a byte-addressed
// big-endian memory model with programmable cache hit delays.
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    localparam int XLEN = 32;
    localparam int MW   = 8;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    lsu_op_t     req_op;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;
    logic        cache_en, cache_write_en;
    logic [31:0] cache_addr, cache_data_in, cache_data_out;
    logic        hit = 1'b0;

    logic [7:0]  mem [64];
    logic [7:0]  ref_mem [64];
    logic [3:0]  widx;
    int          checks = 0, errors = 0;
    int          rd_delay = 0, wr_delay = 0, phase_cnt = 0;
    int          en_cycles = 0, we_cycles = 0, wr_count = 0, addr_bad = 0;
    logic [31:0] exp_caddr = '0;

    always #5 clk = ~clk;

    mips_lsu #(.XLEN(XLEN), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
        .cache_en(cache_en), .cache_addr(cache_addr), .cache_write_en(cache_write_en),
        .cache_data_in(cache_data_in), .cache_data_out(cache_data_out), .hit(hit)
    );

    assign widx = cache_addr[5:2];
    assign cache_data_out = {mem[{widx, 2'd0}], mem[{widx, 2'd1}], mem[{widx, 2'd2}], mem[{widx, 2'd3}]};

    // Cache model: hit after a programmed number of wait cycles per access phase.
    always @(negedge clk) begin
        if (!cache_en) begin
            hit = 1'b0;
            phase_cnt = 0;
        end else begin
            en_cycles++;
            if (cache_write_en) we_cycles++;
            if (cache_addr !== exp_caddr) addr_bad++;
            hit = (phase_cnt == (cache_write_en ? wr_delay : rd_delay));
            if (hit) begin
                phase_cnt = 0;
                if (cache_write_en) begin
                    wr_count++;
                    mem[{widx, 2'd0}] = cache_data_in[31:24];
                    mem[{widx, 2'd1}] = cache_data_in[23:16];
                    mem[{widx, 2'd2}] = cache_data_in[15:8];
                    mem[{widx, 2'd3}] = cache_data_in[7:0];
                end
            end else begin
                phase_cnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] addr, input bit use_ref);
        int b;
        b = int'(addr[5:2]) * 4;
        if (use_ref) return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
        return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input int d1, input int d2);
        int          n, lat, exp_lat, exp_writes, exp_we, idx;
        bit          got, is_err;
        longint      val;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        n = 1 << op[1:0];
        if (op[3] && n == 4) wr_delay = d1;
        else begin
            rd_delay = d1;
            wr_delay = d2;
        end
        @(negedge clk);
        en_cycles = 0; we_cycles = 0; wr_count = 0; addr_bad = 0;
        exp_caddr = addr & 32'hFFFF_FFFC;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        exp_err = 2'd0; exp_rdata = '0; exp_lat = -1; exp_writes = 0; exp_we = 0; is_err = 1'b0;
        if (n > 4) begin
            exp_err = 2'd3; is_err = 1'b1;
        end else if (addr % n != 0) begin
            exp_err = 2'd1; is_err = 1'b1;
        end else if (!op[3]) begin
            if (d1 >= MW) begin
                exp_err = 2'd2; exp_lat = MW + 1;
            end else begin
                val = 0;
                for (int i = 0; i < n; i++) begin
                    idx = int'((addr + 32'(i)) & 32'd63);
                    val = (val << 8) | longint'(ref_mem[idx]);
                end
                if (!op[2] && ((val >> (8*n-1)) & 1) == 1) val = val - (longint'(1) << (8*n));
                exp_rdata = val[31:0];
                exp_lat = d1 + 2;
            end
        end else if (n == 4 && d1 >= MW) begin
            exp_err = 2'd2; exp_lat = MW + 1; exp_we = MW;
        end else if (n < 4 && d1 >= MW) begin
            exp_err = 2'd2; exp_lat = MW + 1;
        end else if (n < 4 && d2 >= MW) begin
            exp_err = 2'd2; exp_lat = d1 + MW + 2; exp_we = MW;
        end else begin
            exp_writes = 1;
            exp_lat = (n == 4) ? d1 + 2 : d1 + d2 + 3;
            exp_we  = (n == 4) ? d1 + 1 : d2 + 1;
            for (int i = 0; i < n; i++) begin
                idx = int'((addr + 32'(i)) & 32'd63);
                ref_mem[idx] = 8'(wdata >> (8*(n-1-i)));
            end
        end
        checkOutput("resp_seen", 64'(got), 64'd1);
        checkOutput("resp_rdata", 64'(resp_rdata), 64'(exp_rdata));
        checkOutput("resp_err", 64'(resp_err), 64'(exp_err));
        checkOutput("resp_rd", 64'(resp_rd), 64'(rd));
        if (exp_lat >= 0) checkOutput("latency", 64'(lat), 64'(exp_lat));
        if (is_err) checkOutput("err_no_cache", 64'(en_cycles), 64'd0);
        if (op[3] && !is_err) checkOutput("we_cycles", 64'(we_cycles), 64'(exp_we));
        checkOutput("cache_writes", 64'(wr_count), 64'(exp_writes));
        checkOutput("cache_addr", 64'(addr_bad), 64'd0);
        checkOutput("mem_word", 64'(memWord(addr, 1'b0)), 64'(memWord(addr, 1'b1)));
        @(negedge clk);
        checkOutput("resp_pulse", 64'(resp_valid), 64'd0);
    endtask

    function automatic int randDelay();
        if ($urandom_range(0, 9) == 0) return MW + int'($urandom_range(0, 2));
        return int'($urandom_range(0, MW - 1));
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        req_op = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        checkOutput("rst_cache_en", 64'(cache_en), 64'd0);
        checkOutput("rst_cache_addr", 64'(cache_addr), 64'd0);
        rst_b = 1'b1;

        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hF4;
        for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
        applyStimulus(4'b0000, 32'h103, 32'h0, 5'd3, 0, 0);
        checkOutput("lb_value", 64'(resp_rdata), 64'hFFFF_FFF4);
        applyStimulus(4'b0101, 32'h102, 32'h0, 5'd4, 0, 0);
        checkOutput("lhu_value", 64'(resp_rdata), 64'h0000_33F4);
        applyStimulus(4'b0001, 32'h101, 32'h0, 5'd5, 0, 0);
        checkOutput("lh_misalign", 64'(resp_err), 64'd1);
        mem[3] = 8'h44; ref_mem[3] = 8'h44;
        applyStimulus(4'b1000, 32'h101, 32'hAB, 5'd6, 0, 0);
        checkOutput("sb_merge", 64'(memWord(32'h100, 1'b0)), 64'h11AB_3344);
        applyStimulus(4'b1010, 32'h200, 32'hDEAD_BEEF, 5'd7, 5, 0);
        checkOutput("sw_we_cycles", 64'(we_cycles), 64'd6);
        checkOutput("sw_data", 64'(memWord(32'h200, 1'b0)), 64'hDEAD_BEEF);
        applyStimulus(4'b0010, 32'h104, 32'h0, 5'd8, 1000, 0);
        checkOutput("lw_timeout", 64'(resp_err), 64'd2);
        applyStimulus(4'b1011, 32'h108, 32'h1234, 5'd9, 0, 0);
        checkOutput("sd_illegal", 64'(resp_err), 64'd3);

        for (int t = 0; t < 250; t++)
            applyStimulus(4'($urandom_range(0, 15)), 32'($urandom_range(0, 255)), $urandom,
                          5'($urandom), randDelay(), randDelay());

        // Reset while the RMW write phase is waiting for a hit.
        rd_delay = 0; wr_delay = 1000;
        @(negedge clk);
        exp_caddr = 32'h40;
        req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h41; req_wdata = 32'h5A; req_rd = 5'd1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            seen = cache_write_en;
        end
        checkOutput("rmw_wr_reached", 64'(seen), 64'd1);
        #2 rst_b = 1'b0;
        #1;
        checkOutput("rst_we_drop", 64'(cache_write_en), 64'd0);
        checkOutput("rst_en_drop", 64'(cache_en), 64'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_no_resp", 64'(resp_valid), 64'd0);
        end
        rst_b = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("post_rst_ready", 64'(req_ready), 64'd1);
            checkOutput("post_rst_no_resp", 64'(resp_valid), 64'd0);
        end
        checkOutput("rst_no_write", 64'(memWord(32'h40, 1'b0)), 64'(memWord(32'h40, 1'b1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
